// File: rtl/proc_pkg.sv
// Shared definitions for the processor memory path: data/address widths and
// the encoding of which requester owns the read returning from memory.
package proc_pkg;

  localparam int WORD_SIZE_DEF  = 32;
  localparam int ADDR_WIDTH_DEF = 16;

  typedef logic [1:0] owner_t;

  localparam owner_t OWNER_NONE = 2'd0;
  localparam owner_t OWNER_IF   = 2'd1;
  localparam owner_t OWNER_DM   = 2'd2;

  // Owner of the read data that will come back next cycle for this cycle's grant.
  // Stores and idle cycles produce no read data.
  function automatic owner_t read_owner(input logic grant_if,
                                        input logic grant_dm,
                                        input logic dm_wren);
    owner_t owner;
    owner = OWNER_NONE;
    if (grant_if) begin
      owner = OWNER_IF;
    end else if (grant_dm && !dm_wren) begin
      owner = OWNER_DM;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Priority decision between fetch (IF) and data (DM) requesters.
// DM normally wins contention; after MAX_DM_STREAK contended DM grants the
// fetch side is forced through so the pipeline front end cannot starve.
module mem_arb_grant
  import proc_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_flush,
  input  logic dm_req,
  output logic grant_if,
  output logic grant_dm
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          if_eligible;
  logic          streak_full;

  assign if_eligible = if_req & ~if_flush;
  assign streak_full = (streak_q == STREAK_MAX);

  // Combinational grant; nothing is granted while reset is asserted.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (!rst) begin
      if (dm_req && !(if_eligible && streak_full)) begin
        grant_dm = 1'b1;
      end else if (if_eligible) begin
        grant_if = 1'b1;
      end
    end
  end

  // Streak counts only DM grants that actually blocked an eligible fetch.
  always_comb begin
    streak_d = streak_q;
    if (!if_eligible || grant_if) begin
      streak_d = '0;
    end else if (grant_dm && !streak_full) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Streak register.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port processor memory between instruction fetch and the
// load/store unit: one access per cycle, read data routed back to its owner
// one cycle after the grant.
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int WORD_SIZE     = WORD_SIZE_DEF,
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_ack,
  output logic                  if_rvalid,
  output logic [WORD_SIZE-1:0]  if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_wren,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [WORD_SIZE-1:0]  dm_wdata,
  output logic                  dm_ack,
  output logic                  dm_rvalid,
  output logic [WORD_SIZE-1:0]  dm_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_data,
  output logic                  mem_wren,
  input  logic [WORD_SIZE-1:0]  mem_q
);

  logic   grant_if;
  logic   grant_dm;
  owner_t rd_owner_q;
  owner_t rd_owner_d;

  mem_arb_grant #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) u_grant (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_flush(if_flush),
    .dm_req  (dm_req),
    .grant_if(grant_if),
    .grant_dm(grant_dm)
  );

  assign if_ack = grant_if;
  assign dm_ack = grant_dm;

  // Memory drive: idle cycles keep the fetch address on the bus.
  always_comb begin
    mem_addr = if_addr;
    mem_data = '0;
    mem_wren = 1'b0;
    if (grant_dm) begin
      mem_addr = dm_addr;
      mem_data = dm_wdata;
      mem_wren = dm_wren & ~rst;
    end
  end

  // Next read owner follows this cycle's read grant.
  always_comb begin
    rd_owner_d = read_owner(grant_if, grant_dm, dm_wren);
  end

  // Read owner register; reset discards any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner_q <= OWNER_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  // Return-path qualifiers; a flush in the return cycle drops fetch data.
  always_comb begin
    if_rvalid = (rd_owner_q == OWNER_IF) & ~if_flush & ~rst;
    dm_rvalid = (rd_owner_q == OWNER_DM) & ~rst;
  end

  assign if_rdata = mem_q;
  assign dm_rdata = mem_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port `processor_memory` between two requesters: instruction fetch (IF, read-only) and data load/store (DM, read/write). Memory is word-addressed with synchronous read, so `q` is valid one cycle after the address is presented. The block sits between `program_counter`/fetch logic, the load/store unit and `processor_memory` in the RISC_V top. It issues one access per cycle and routes read data back to the requester that issued it.

Parameters:
WORD_SIZE, 32, data width in bits
ADDR_WIDTH, 16, word-address width presented to memory
MAX_DM_STREAK, 4, maximum consecutive contended DM grants before IF is forced through (≥1)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held until if_ack
if_addr  input  ADDR_WIDTH  fetch word address
if_flush  input  1  branch/redirect; kills fetch grant and in-flight fetch data this cycle
if_ack  output  1  fetch request accepted this cycle
if_rvalid  output  1  if_rdata valid this cycle
if_rdata  output  WORD_SIZE  fetch read data
dm_req  input  1  data request; held with addr/wdata/wren until dm_ack
dm_wren  input  1  1 = store, 0 = load
dm_addr  input  ADDR_WIDTH  data word address
dm_wdata  input  WORD_SIZE  store data
dm_ack  output  1  data request accepted this cycle
dm_rvalid  output  1  dm_rdata valid (loads only)
dm_rdata  output  WORD_SIZE  load data
mem_addr  output  ADDR_WIDTH  to processor_memory.address
mem_data  output  WORD_SIZE  to processor_memory.data
mem_wren  output  1  to processor_memory.wren
mem_q  input  WORD_SIZE  from processor_memory.q, 1-cycle latency

Behaviour:
- Interface: single clock `clk`; reset `rst` is synchronous, active-high.
- Grant is combinational from the current requests and registered state:
  - if_eligible = if_req & ~if_flush
  - dm_req only → DM
  - if_eligible only → IF
  - both → DM, unless streak == MAX_DM_STREAK, then IF
  - neither → no grant
- ack = grant; high exactly in the grant cycle. Requester may change or drop the request the next cycle. No ack while rst is high.
- Memory drive:
  - mem_addr/mem_data = granted requester's addr/wdata; if idle, mem_addr = if_addr and mem_data = 0.
  - mem_wren = DM grant & dm_wren & ~rst.
- streak counter (0..MAX_DM_STREAK):
  - increments (saturating) on a DM grant while if_eligible is high
  - clears on an IF grant, or on any cycle with if_eligible low
  - resets to 0
- Read tracking uses register rd_owner {NONE, IF, DM}:
  - next value = owner of this cycle's read grant (a store or no grant gives NONE)
  - cycle after a grant: rvalid for that owner = 1, its rdata = mem_q
  - if_rvalid = (rd_owner == IF) & ~if_flush; a flush in the return cycle drops the data
  - if_rdata/dm_rdata are wired to mem_q permanently; meaningful only with rvalid
- Throughput: back-to-back grants allowed every cycle; read latency is 1 cycle from ack to rvalid.
- Stores: dm_ack only, no dm_rvalid.
- Read-after-write to the same address in consecutive cycles returns the new data (memory is in write-first/new-data mode).
- Reset values: if_ack = dm_ack = 0, if_rvalid = dm_rvalid = 0, mem_wren = 0, streak = 0, rd_owner = NONE.
- Reset mid-operation: an in-flight read is discarded, so no rvalid in the cycle after rst.
- Simultaneous flush and IF-only request: no grant, memory idle, no mem_wren.

Decomposition:
- Shared package `proc_pkg`:
  - rd_owner encoding constants: OWNER_NONE = 2'd0, OWNER_IF = 2'd1, OWNER_DM = 2'd2
  - default ADDR_WIDTH, WORD_SIZE
- One natural sub-module: `mem_arb_grant`. It holds the combinational priority decision plus the streak counter and outputs grant_if/grant_dm. The top keeps the muxing and rd_owner.

Test Plan:
- IF-only reads: memory preloaded mem[0..3] = 0x10,0x20,0x30,0x40; if_req held with if_addr 0..3 over 4 cycles → if_ack every cycle; if_rvalid the following cycle each time with data 0x10,0x20,0x30,0x40; dm_rvalid stays 0.
- Store then load: dm store addr 5, data 0xDEADBEEF, then dm load addr 5 next cycle → mem_wren = 1 for one cycle; dm_rvalid one cycle after the load ack with 0xDEADBEEF; no dm_rvalid for the store.
- Starvation guard (MAX_DM_STREAK = 4): if_req and dm_req held high continuously → 4 DM grants, 1 IF grant, then repeats (pattern D,D,D,D,I,D,D,D,D,I).
- Flush: IF read of addr 2 acked; if_flush = 1 in the next cycle → if_rvalid = 0 that cycle; no IF grant while flush is high.
- Reset mid-read: DM load acked, rst = 1 next cycle → dm_rvalid = 0, acks 0, mem_wren 0; after rst drops, a fresh IF request is acked the same cycle.
